emul_bus_arbiter: RTL and testbench
===================================

EMUL_BUS_ARBITER -- requirements
Module: emul_bus_arbiter

Interface
REQ-001 Parameter PULSE_W, default 4: strobe width in Clk cycles (range 1..15).
REQ-002 Parameter RDY_TIMEOUT, default 1000: maximum Clk cycles spent waiting for ms6205_ready.
REQ-003 Clk  in  1  single system clock; all logic is rising-edge.
REQ-004 Rst_n  in  1  reset, synchronous, active-low.
REQ-005 in12_req  in  1  IN-12 refresh request (level), with in12_anode  in  8 and in12_cathode  in  8.
REQ-006 ms_req  in  1  MS6205 write request (level), with ms_addr  in  8 and ms_data  in  8.
REQ-007 kb_req  in  1  keyboard scan request (level), with kb_col  in  8.
REQ-008 keyboard_data_in  in  7  keyboard row sense; ms6205_ready  in  1  display ready.
REQ-009 emulData  out  8  shared bus to emulator board.
REQ-010 The strobes are all outputs of width 1: in12_clear, in12_write_anode, in12_write_cathode, ms6205_write_addr, ms6205_write_data, keyboard_write, keyboard_read, keyboard_clear.
REQ-011 The per-requester outputs are in12_done, ms_done, kb_done and ms_err (each out, width 1, one-cycle pulses), kb_row (out, 7, latched row) and busy (out, 1).

Function
REQ-012 Transactions: IN12 = clear(0x00), anode(in12_anode), cathode(in12_cathode); MS = wait-ready, addr(ms_addr), data(ms_data); KB = write(kb_col), read(0x00), clear(0x00).
REQ-013 Each phase SHALL be SETUP 1 cycle (bus driven, strobe low), then STROBE PULSE_W cycles (bus held, that phase's strobe high), then HOLD 1 cycle (bus held, strobe low).
REQ-014 FSM states: IDLE, WAIT_RDY, SETUP, STROBE, HOLD; in IDLE emulData=0x00, all strobes low, busy=0.
REQ-015 In IDLE, requests sampled at cycle N SHALL produce SETUP of the first phase at cycle N+1.
REQ-016 Arbitration SHALL be round-robin in the order IN12 -> MS -> KB, with search starting after the last granted requester; after reset, IN12 has highest priority.
REQ-017 A grant is held until the transaction ends; request deassertion mid-transaction is ignored; the requester holds its data stable until done.
REQ-018 The done pulse SHALL be asserted in the cycle after the final HOLD; FSM returns to IDLE in that same cycle and may re-arbitrate on the following cycle.
REQ-019 Latency with PULSE_W=4: 3-phase transaction = 18 cycles SETUP-to-last-HOLD; done at N+19.
REQ-020 WAIT_RDY: proceed to addr SETUP in the cycle after ms6205_ready is sampled high (0 extra cycles if already high on entry).
REQ-021 If ms6205_ready stays low for RDY_TIMEOUT cycles, assert ms_err (not ms_done), emit no strobes, return to IDLE; MS counts as granted for round-robin.
REQ-022 kb_row SHALL capture keyboard_data_in on the last STROBE cycle of the read phase; it holds otherwise and is 0 after reset.
REQ-023 At most one strobe high in any cycle; no strobe is asserted in SETUP, HOLD, IDLE or WAIT_RDY.
REQ-024 busy=1 in every non-IDLE state.

Reset
REQ-025 When Rst_n is low at a Clk edge: state=IDLE, emulData=0x00, all strobes/done/ms_err=0, kb_row=0, round-robin pointer=IN12, timers cleared.
REQ-026 Reset mid-transaction SHALL abort without completing the phase or pulsing done.

Structure
REQ-027 Package emul_bus_pkg SHALL hold the state enum, requester enum (REQ_IN12, REQ_MS, REQ_KB) and phase-descriptor typedef (strobe select, bus source).
REQ-028 Sub-module strobe_timer (load, PULSE_W count, last-cycle flag) SHALL time STROBE and WAIT_RDY; the remainder is one FSM.

Verification
REQ-029 in12_req=1, anode 0x04, cathode 0x35 -> bus 0x00/0x04/0x35; in12_clear, in12_write_anode, in12_write_cathode each high 4 cycles; in12_done at N+19.
REQ-030 All three requests at cycle N after reset -> grant order IN12, MS, KB; re-asserting all -> IN12 next, and no requester is starved across 6 transactions.
REQ-031 ms_req, ready low 10 cycles then high -> addr SETUP 1 cycle after ready; ms_done once; ready never high with RDY_TIMEOUT=1000 -> ms_err at 1000 cycles with no strobes.
REQ-032 kb_col=0x08, keyboard_data_in=0x2A during read strobe -> kb_row=0x2A after kb_done; the value is unchanged by later input toggles.
REQ-033 Rst_n low during ms data STROBE -> next cycle all outputs 0 and no ms_done; the bench asserts one-hot strobes and stable bus during STROBE throughout.

Source files
------------

// File: rtl/emul_bus_pkg.sv
// Shared types and helpers for the emulator bus arbiter: FSM states,
// requester identities, per-phase descriptors and round-robin selection.
package emul_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        REQ_IN12 = 2'd0,
        REQ_MS   = 2'd1,
        REQ_KB   = 2'd2
    } req_e;

    typedef enum logic [3:0] {
        STB_NONE         = 4'd0,
        STB_IN12_CLEAR   = 4'd1,
        STB_IN12_ANODE   = 4'd2,
        STB_IN12_CATHODE = 4'd3,
        STB_MS_ADDR      = 4'd4,
        STB_MS_DATA      = 4'd5,
        STB_KB_WRITE     = 4'd6,
        STB_KB_READ      = 4'd7,
        STB_KB_CLEAR     = 4'd8
    } strobe_e;

    typedef enum logic [2:0] {
        SRC_ZERO         = 3'd0,
        SRC_IN12_ANODE   = 3'd1,
        SRC_IN12_CATHODE = 3'd2,
        SRC_MS_ADDR      = 3'd3,
        SRC_MS_DATA      = 3'd4,
        SRC_KB_COL       = 3'd5
    } bus_src_e;

    typedef struct packed {
        strobe_e  stb;
        bus_src_e src;
    } phase_desc_t;

    // Index of the final bus phase for each requester (MS has two bus
    // phases; its ready wait is not a bus phase).
    function automatic logic [1:0] last_phase(input req_e r);
        logic [1:0] lp;
        case (r)
            REQ_IN12: lp = 2'd2;
            REQ_MS:   lp = 2'd1;
            REQ_KB:   lp = 2'd2;
            default:  lp = 2'd0;
        endcase
        return lp;
    endfunction

    // Strobe select and bus source for phase idx of requester r.
    function automatic phase_desc_t phase_desc(input req_e r, input logic [1:0] idx);
        phase_desc_t d;
        d.stb = STB_NONE;
        d.src = SRC_ZERO;
        case (r)
            REQ_IN12: begin
                case (idx)
                    2'd0:    begin d.stb = STB_IN12_CLEAR;   d.src = SRC_ZERO;         end
                    2'd1:    begin d.stb = STB_IN12_ANODE;   d.src = SRC_IN12_ANODE;   end
                    2'd2:    begin d.stb = STB_IN12_CATHODE; d.src = SRC_IN12_CATHODE; end
                    default: begin d.stb = STB_NONE;         d.src = SRC_ZERO;         end
                endcase
            end
            REQ_MS: begin
                case (idx)
                    2'd0:    begin d.stb = STB_MS_ADDR; d.src = SRC_MS_ADDR; end
                    2'd1:    begin d.stb = STB_MS_DATA; d.src = SRC_MS_DATA; end
                    default: begin d.stb = STB_NONE;    d.src = SRC_ZERO;    end
                endcase
            end
            REQ_KB: begin
                case (idx)
                    2'd0:    begin d.stb = STB_KB_WRITE; d.src = SRC_KB_COL; end
                    2'd1:    begin d.stb = STB_KB_READ;  d.src = SRC_ZERO;   end
                    2'd2:    begin d.stb = STB_KB_CLEAR; d.src = SRC_ZERO;   end
                    default: begin d.stb = STB_NONE;     d.src = SRC_ZERO;   end
                endcase
            end
            default: begin
                d.stb = STB_NONE;
                d.src = SRC_ZERO;
            end
        endcase
        return d;
    endfunction

    // One-hot strobe vector: bit0 in12_clear .. bit7 keyboard_clear.
    function automatic logic [7:0] strobe_onehot(input strobe_e s);
        logic [7:0] v;
        case (s)
            STB_IN12_CLEAR:   v = 8'h01;
            STB_IN12_ANODE:   v = 8'h02;
            STB_IN12_CATHODE: v = 8'h04;
            STB_MS_ADDR:      v = 8'h08;
            STB_MS_DATA:      v = 8'h10;
            STB_KB_WRITE:     v = 8'h20;
            STB_KB_READ:      v = 8'h40;
            STB_KB_CLEAR:     v = 8'h80;
            default:          v = 8'h00;
        endcase
        return v;
    endfunction

    // Round-robin pick in the order IN12 -> MS -> KB, starting after last.
    // reqs: bit0 IN12, bit1 MS, bit2 KB. Caller guarantees reqs != 0.
    function automatic req_e rr_pick(input req_e last, input logic [2:0] reqs);
        req_e g;
        case (last)
            REQ_IN12: begin
                if (reqs[1])      g = REQ_MS;
                else if (reqs[2]) g = REQ_KB;
                else              g = REQ_IN12;
            end
            REQ_MS: begin
                if (reqs[2])      g = REQ_KB;
                else if (reqs[0]) g = REQ_IN12;
                else              g = REQ_MS;
            end
            default: begin
                if (reqs[0])      g = REQ_IN12;
                else if (reqs[1]) g = REQ_MS;
                else              g = REQ_KB;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/strobe_timer.sv
// Down-counter timing both strobe pulses and the display-ready timeout.
// 'last' is high in the final cycle of a loaded interval.
module strobe_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == W'(1));

endmodule

// File: rtl/emul_bus_arbiter.sv
// Round-robin arbiter serialising IN-12, MS6205 and keyboard transactions
// onto the shared emulator bus as SETUP / STROBE / HOLD phases.
module emul_bus_arbiter
    import emul_bus_pkg::*;
#(
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned RDY_TIMEOUT = 1000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       in12_req,
    input  logic [7:0] in12_anode,
    input  logic [7:0] in12_cathode,
    input  logic       ms_req,
    input  logic [7:0] ms_addr,
    input  logic [7:0] ms_data,
    input  logic       kb_req,
    input  logic [7:0] kb_col,
    input  logic [6:0] keyboard_data_in,
    input  logic       ms6205_ready,
    output logic [7:0] emulData,
    output logic       in12_clear,
    output logic       in12_write_anode,
    output logic       in12_write_cathode,
    output logic       ms6205_write_addr,
    output logic       ms6205_write_data,
    output logic       keyboard_write,
    output logic       keyboard_read,
    output logic       keyboard_clear,
    output logic       in12_done,
    output logic       ms_done,
    output logic       kb_done,
    output logic       ms_err,
    output logic [6:0] kb_row,
    output logic       busy
);

    localparam int TMR_W = ($clog2(RDY_TIMEOUT + 1) > 4) ? $clog2(RDY_TIMEOUT + 1) : 4;

    state_e      state_r, state_nxt_s;
    req_e        grant_r, grant_nxt_s;
    req_e        last_r, last_nxt_s;
    req_e        pick_s;
    logic [1:0]  phase_r, phase_nxt_s;
    logic [2:0]  req_vec_s;
    logic        tmr_load_s;
    logic [TMR_W-1:0] tmr_val_s;
    logic        tmr_last_s;
    logic [2:0]  done_nxt_s, done_r;
    logic        ms_err_nxt_s, ms_err_r;
    phase_desc_t desc_nxt_s;
    logic [7:0]  bus_sel_s, bus_nxt_s, bus_r;
    logic [7:0]  stb_nxt_s, stb_r;
    logic        busy_nxt_s, busy_r;
    logic [6:0]  kb_row_r;
    logic        kb_capture_s;

    assign req_vec_s = {kb_req, ms_req, in12_req};
    assign pick_s    = rr_pick(last_r, req_vec_s);

    strobe_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .last     (tmr_last_s)
    );

    // Next-state logic: arbitration, phase sequencing and done/err pulses.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        last_nxt_s   = last_r;
        phase_nxt_s  = phase_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TMR_W{1'b0}};
        done_nxt_s   = 3'b000;
        ms_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_vec_s != 3'b000) begin
                    grant_nxt_s = pick_s;
                    last_nxt_s  = pick_s;
                    phase_nxt_s = 2'd0;
                    if ((pick_s == REQ_MS) && !ms6205_ready) begin
                        state_nxt_s = ST_WAIT_RDY;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = TMR_W'(RDY_TIMEOUT);
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (ms6205_ready) begin
                    state_nxt_s = ST_SETUP;
                end else if (tmr_last_s) begin
                    state_nxt_s  = ST_IDLE;
                    ms_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_RDY;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_STROBE;
                tmr_load_s  = 1'b1;
                tmr_val_s   = TMR_W'(PULSE_W);
            end
            ST_STROBE: begin
                if (tmr_last_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (phase_r == last_phase(grant_r)) begin
                    state_nxt_s = ST_IDLE;
                    case (grant_r)
                        REQ_IN12: done_nxt_s = 3'b001;
                        REQ_MS:   done_nxt_s = 3'b010;
                        REQ_KB:   done_nxt_s = 3'b100;
                        default:  done_nxt_s = 3'b000;
                    endcase
                end else begin
                    state_nxt_s = ST_SETUP;
                    phase_nxt_s = phase_r + 2'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus and strobe values for the upcoming cycle, registered below.
    always_comb begin
        desc_nxt_s = phase_desc(grant_nxt_s, phase_nxt_s);
        case (desc_nxt_s.src)
            SRC_IN12_ANODE:   bus_sel_s = in12_anode;
            SRC_IN12_CATHODE: bus_sel_s = in12_cathode;
            SRC_MS_ADDR:      bus_sel_s = ms_addr;
            SRC_MS_DATA:      bus_sel_s = ms_data;
            SRC_KB_COL:       bus_sel_s = kb_col;
            default:          bus_sel_s = 8'h00;
        endcase
        if ((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) || (state_nxt_s == ST_HOLD)) begin
            bus_nxt_s = bus_sel_s;
        end else begin
            bus_nxt_s = 8'h00;
        end
        if (state_nxt_s == ST_STROBE) begin
            stb_nxt_s = strobe_onehot(desc_nxt_s.stb);
        end else begin
            stb_nxt_s = 8'h00;
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= REQ_IN12;
            last_r   <= REQ_KB;
            phase_r  <= 2'd0;
            bus_r    <= 8'h00;
            stb_r    <= 8'h00;
            done_r   <= 3'b000;
            ms_err_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            last_r   <= last_nxt_s;
            phase_r  <= phase_nxt_s;
            bus_r    <= bus_nxt_s;
            stb_r    <= stb_nxt_s;
            done_r   <= done_nxt_s;
            ms_err_r <= ms_err_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign kb_capture_s = (state_r == ST_STROBE) && (grant_r == REQ_KB) &&
                          (phase_r == 2'd1) && tmr_last_s;

    // Latch the keyboard row on the final cycle of the read strobe.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            kb_row_r <= 7'h00;
        end else if (kb_capture_s) begin
            kb_row_r <= keyboard_data_in;
        end else begin
            kb_row_r <= kb_row_r;
        end
    end

    assign emulData           = bus_r;
    assign in12_clear         = stb_r[0];
    assign in12_write_anode   = stb_r[1];
    assign in12_write_cathode = stb_r[2];
    assign ms6205_write_addr  = stb_r[3];
    assign ms6205_write_data  = stb_r[4];
    assign keyboard_write     = stb_r[5];
    assign keyboard_read      = stb_r[6];
    assign keyboard_clear     = stb_r[7];
    assign in12_done          = done_r[0];
    assign ms_done            = done_r[1];
    assign kb_done            = done_r[2];
    assign ms_err             = ms_err_r;
    assign kb_row             = kb_row_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_emul_bus_arbiter.sv
// Directed bench for emul_bus_arbiter: cycle-exact transaction traces,
// round-robin order, ready wait/timeout, keyboard row latch, mid-run reset.
module tb_emul_bus_arbiter;

    localparam int PW     = 4;
    localparam int PH     = PW + 2;
    localparam int RDY_TO = 1000;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       in12_req, ms_req, kb_req, ms6205_ready;
    logic [7:0] in12_anode, in12_cathode, ms_addr, ms_data, kb_col;
    logic [6:0] keyboard_data_in;
    logic [7:0] emulData;
    logic       in12_clear, in12_write_anode, in12_write_cathode;
    logic       ms6205_write_addr, ms6205_write_data;
    logic       keyboard_write, keyboard_read, keyboard_clear;
    logic       in12_done, ms_done, kb_done, ms_err, busy;
    logic [6:0] kb_row;
    logic [7:0] stb;
    logic [7:0] prev_bus;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    emul_bus_arbiter #(
        .PULSE_W     (PW),
        .RDY_TIMEOUT (RDY_TO)
    ) dut (
        .Clk                (Clk),
        .Rst_n              (Rst_n),
        .in12_req           (in12_req),
        .in12_anode         (in12_anode),
        .in12_cathode       (in12_cathode),
        .ms_req             (ms_req),
        .ms_addr            (ms_addr),
        .ms_data            (ms_data),
        .kb_req             (kb_req),
        .kb_col             (kb_col),
        .keyboard_data_in   (keyboard_data_in),
        .ms6205_ready       (ms6205_ready),
        .emulData           (emulData),
        .in12_clear         (in12_clear),
        .in12_write_anode   (in12_write_anode),
        .in12_write_cathode (in12_write_cathode),
        .ms6205_write_addr  (ms6205_write_addr),
        .ms6205_write_data  (ms6205_write_data),
        .keyboard_write     (keyboard_write),
        .keyboard_read      (keyboard_read),
        .keyboard_clear     (keyboard_clear),
        .in12_done          (in12_done),
        .ms_done            (ms_done),
        .kb_done            (kb_done),
        .ms_err             (ms_err),
        .kb_row             (kb_row),
        .busy               (busy)
    );

    assign stb = {keyboard_clear, keyboard_read, keyboard_write, ms6205_write_data,
                  ms6205_write_addr, in12_write_cathode, in12_write_anode, in12_clear};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {busy, bus, strobes} for cycle k of a transaction (k=0 is first SETUP).
    function automatic logic [16:0] exp_phase(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input int s0, input int s1, input int s2);
        int p;
        int off;
        int s;
        logic [7:0] b;
        logic [7:0] st;
        p   = k / PH;
        off = k % PH;
        if (p == 0) begin
            b = b0; s = s0;
        end else if (p == 1) begin
            b = b1; s = s1;
        end else begin
            b = b2; s = s2;
        end
        st = 8'h01 << s;
        if (!((off >= 1) && (off <= PW))) st = 8'h00;
        return {1'b1, b, st};
    endfunction

    task automatic set_req(input int r, input logic v);
        case (r)
            0:       in12_req = v;
            1:       ms_req   = v;
            default: kb_req   = v;
        endcase
    endtask

    // Follow one granted transaction from its first SETUP through the done cycle.
    task automatic run_phases(input string tag, input int r, input bit drop_early, input logic [6:0] kb_val);
        logic [7:0] b0, b1, b2;
        int s0, s1, s2, nph;
        logic [3:0] dn;
        case (r)
            0: begin
                nph = 3; b0 = 8'h00; b1 = in12_anode; b2 = in12_cathode; s0 = 0; s1 = 1; s2 = 2;
            end
            1: begin
                nph = 2; b0 = ms_addr; b1 = ms_data; b2 = 8'h00; s0 = 3; s1 = 4; s2 = 0;
            end
            default: begin
                nph = 3; b0 = kb_col; b1 = 8'h00; b2 = 8'h00; s0 = 5; s1 = 6; s2 = 7;
            end
        endcase
        for (int k = 0; k < nph * PH; k++) begin
            @(negedge Clk);
            check(tag, {15'h0, busy, emulData, stb}, {15'h0, exp_phase(k, b0, b1, b2, s0, s1, s2)});
            if ((k == 0) && drop_early) set_req(r, 1'b0);
            keyboard_data_in = (k == PH + PW) ? kb_val : ~kb_val;
        end
        @(negedge Clk);
        dn = 4'b1000 >> r;
        check({tag, "_done"}, {11'h0, in12_done, ms_done, kb_done, ms_err, busy, emulData, stb},
              {11'h0, dn, 1'b0, 8'h00, 8'h00});
        set_req(r, 1'b0);
        if (r == 2) check({tag, "_kb_row"}, {25'h0, kb_row}, {25'h0, kb_val});
    endtask

    // Throughout the run: strobes one-hot and bus unchanged while any strobe is high.
    always @(negedge Clk) begin
        if (Rst_n && (stb != 8'h00)) begin
            check("strobe_onehot", $countones(stb), 32'd1);
            check("bus_stable", {24'h0, emulData}, {24'h0, prev_bus});
        end
        prev_bus <= emulData;
    end

    initial begin
        int bad;
        Rst_n = 1'b0;
        in12_req = 1'b0; ms_req = 1'b0; kb_req = 1'b0; ms6205_ready = 1'b0;
        in12_anode = 8'h00; in12_cathode = 8'h00; ms_addr = 8'h00; ms_data = 8'h00;
        kb_col = 8'h00; keyboard_data_in = 7'h00;
        repeat (3) @(negedge Clk);
        check("reset_outs", {converted_outs()}, 32'h0);
        check("reset_kb_row", {25'h0, kb_row}, 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("idle_outs", {converted_outs()}, 32'h0);

        // IN12 refresh; request dropped after the first cycle must be ignored.
        in12_anode = 8'h04; in12_cathode = 8'h35; in12_req = 1'b1;
        run_phases("in12", 0, 1'b1, 7'h00);
        @(negedge Clk);
        check("in12_no_retrigger", {31'h0, busy}, 32'h0);

        // MS write with ready low for 10 cycles.
        ms_addr = 8'h5A; ms_data = 8'hC3; ms6205_ready = 1'b0; ms_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            check("ms_wait", {15'h0, busy, emulData, stb}, {15'h0, 1'b1, 16'h0000});
            if (i == 10) ms6205_ready = 1'b1;
        end
        run_phases("ms_rdy", 1, 1'b0, 7'h00);

        // Keyboard scan: row latched only on the last read-strobe cycle.
        kb_col = 8'h08; kb_req = 1'b1;
        run_phases("kb", 2, 1'b0, 7'h2A);
        for (int i = 0; i < 4; i++) begin
            keyboard_data_in = 7'h55 ^ 7'(i);
            @(negedge Clk);
        end
        check("kb_row_hold", {25'h0, kb_row}, 32'h2A);

        // Ready never arrives: ms_err after the timeout, no strobes.
        ms6205_ready = 1'b0; ms_req = 1'b1; bad = 0;
        for (int i = 1; i <= RDY_TO; i++) begin
            @(negedge Clk);
            if (!busy || (emulData != 8'h00) || (stb != 8'h00) || ms_err || ms_done) bad++;
        end
        check("ms_timeout_wait", bad, 32'h0);
        @(negedge Clk);
        check("ms_timeout_err", {11'h0, in12_done, ms_done, kb_done, ms_err, busy, emulData, stb},
              {11'h0, 4'b0001, 1'b0, 16'h0000});
        ms_req = 1'b0;

        // MS counted as granted: KB wins over IN12 next.
        in12_req = 1'b1; kb_req = 1'b1;
        run_phases("rr_to_kb", 2, 1'b0, 7'h33);
        run_phases("rr_to_in12", 0, 1'b0, 7'h00);

        // Fresh reset, all three requesting twice: IN12, MS, KB, IN12, MS, KB.
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1; ms6205_ready = 1'b1;
        in12_req = 1'b1; ms_req = 1'b1; kb_req = 1'b1;
        run_phases("rr1_in12", 0, 1'b0, 7'h00);
        run_phases("rr1_ms", 1, 1'b0, 7'h00);
        run_phases("rr1_kb", 2, 1'b0, 7'h2A);
        in12_req = 1'b1; ms_req = 1'b1; kb_req = 1'b1;
        run_phases("rr2_in12", 0, 1'b0, 7'h00);
        run_phases("rr2_ms", 1, 1'b0, 7'h00);
        run_phases("rr2_kb", 2, 1'b0, 7'h15);

        // Reset during the MS data strobe aborts the transaction.
        ms_req = 1'b1;
        for (int k = 0; k <= PH + 2; k++) begin
            @(negedge Clk);
            check("ms_pre_reset", {15'h0, busy, emulData, stb},
                  {15'h0, exp_phase(k, ms_addr, ms_data, 8'h00, 3, 4, 0)});
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        check("reset_mid_outs", {converted_outs()}, 32'h0);
        check("reset_mid_kb_row", {25'h0, kb_row}, 32'h0);
        ms_req = 1'b0; Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("post_reset_quiet", {27'h0, in12_done, ms_done, kb_done, ms_err, busy}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] converted_outs();
        return {11'h0, busy, emulData, stb, in12_done, ms_done, kb_done, ms_err};
    endfunction

endmodule
